piso_serializer: RTL

Parametrised parallel-in/serial-out serializer with a valid/ready input handshake, a run-time bit-order select, and a built-in bit-period timer. It takes one W-bit word, shifts it out on a single serial line with each bit held for CLKS_PER_BIT clocks, and then reports completion. It supersedes bare shift-register-plus-counter assemblies and is the data stage in front of UART TX framing and other serial links.

---
 rtl/piso_serializer.sv | 119 +++++++++++
 1 files changed

// File: rtl/piso_serializer.sv
// Parallel-in / serial-out serializer with valid/ready input handshake,
// run-time bit order, built-in bit-period timer and a done pulse.
module piso_serializer #(
    parameter int   W            = 8,
    parameter int   CLKS_PER_BIT = 16,
    parameter logic IDLE_LEVEL   = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         msb_first,
    input  logic         abort,
    output logic         sout,
    output logic         busy,
    output logic         done
);

    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(W);

    localparam logic [TW-1:0] TICK_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(W - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [TW-1:0] tick_q,  tick_d;
    logic [BW-1:0] bit_q,   bit_d;
    logic          order_q, order_d;
    logic          sout_q,  sout_d;
    logic          done_q,  done_d;

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q == SHIFT);
    assign sout     = sout_q;
    assign done     = done_q;

    // Next-state logic: accept, per-bit timing, advance, finish and abort.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        order_d = order_q;
        sout_d  = sout_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && !abort) begin
                    state_d = SHIFT;
                    shreg_d = in_data;
                    order_d = msb_first;
                    tick_d  = '0;
                    bit_d   = '0;
                    sout_d  = msb_first ? in_data[W-1] : in_data[0];
                end
            end
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                    sout_d  = IDLE_LEVEL;
                    tick_d  = '0;
                    bit_d   = '0;
                end else if (tick_q == TICK_LAST) begin
                    tick_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = IDLE;
                        sout_d  = IDLE_LEVEL;
                        bit_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        bit_d = bit_q + 1'b1;
                        if (order_q) begin
                            shreg_d = {shreg_q[W-2:0], IDLE_LEVEL};
                            sout_d  = shreg_q[W-2];
                        end else begin
                            shreg_d = {IDLE_LEVEL, shreg_q[W-1:1]};
                            sout_d  = shreg_q[1];
                        end
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                sout_d  = IDLE_LEVEL;
            end
        endcase
    end

    // State register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            tick_q  <= '0;
            bit_q   <= '0;
            order_q <= 1'b0;
            sout_q  <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            order_q <= order_d;
            sout_q  <= sout_d;
            done_q  <= done_d;
        end
    end

endmodule
